// File: rtl/mux_arbiter.sv
// Round-robin arbiter steering a shared 4:1 datapath mux to one of four
// requesters, with a bounded wait on the shared resource.
//
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   req[3:0]     : per-requester request (bit i <-> mux select i)
//   mem_ready    : shared resource completed the current access
//   sel[1:0]     : datapath mux select, held at last owner when idle
//   gnt[3:0]     : one-hot grant to the current owner
//   mem_valid    : access request to the shared resource
//   done[3:0]    : one-cycle completion pulse to the owner
//   timeout_err  : one-cycle abort pulse
//   busy         : high whenever the arbiter is not idle
module mux_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       mem_valid,
  output logic [3:0] done,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       mem_valid_q, mem_valid_d;
  logic [3:0] done_q, done_d;
  logic       timeout_err_q, timeout_err_d;
  logic       busy_q, busy_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [1:0] last_q, last_d;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;

  // Search upward from last+1; i=4 wraps back onto last itself.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    gnt_d         = gnt_q;
    mem_valid_d   = mem_valid_q;
    done_d        = 4'b0000;
    timeout_err_d = 1'b0;
    wcnt_d        = wcnt_q;
    last_d        = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d       = win;
          gnt_d       = 4'b0001 << win;
          mem_valid_d = 1'b1;
          last_d      = win;
          wcnt_d      = 8'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Completion wins over a coincident timeout.
        if (mem_ready) begin
          done_d      = gnt_q;
          gnt_d       = 4'b0000;
          mem_valid_d = 1'b0;
          state_d     = RELEASE;
        end else if (wcnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          gnt_d         = 4'b0000;
          mem_valid_d   = 1'b0;
          state_d       = RELEASE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        mem_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= 2'd0;
      gnt_q         <= 4'b0000;
      mem_valid_q   <= 1'b0;
      done_q        <= 4'b0000;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      wcnt_q        <= 8'd0;
      last_q        <= 2'd3;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      gnt_q         <= gnt_d;
      mem_valid_q   <= mem_valid_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      wcnt_q        <= wcnt_d;
      last_q        <= last_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign mem_valid   = mem_valid_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
Parameters:
REQ-001 SHALL have parameter TIMEOUT, default 16: the number of BUSY cycles with mem_ready low before the transaction is aborted. Legal range is 1..255.

Ports:
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port req, input, 4 bits: per-requester request; bit i corresponds to mux select value i (0=a, 1=b, 2=c, 3=d).
REQ-005 SHALL have port mem_ready, input, 1 bit: the shared resource accepted and completed the current access.
REQ-006 SHALL have port sel, output, 2 bits: drives the sel input of the 32-bit 4:1 datapath mux.
REQ-007 SHALL have port gnt, output, 4 bits: one-hot grant to the current owner.
REQ-008 SHALL have port mem_valid, output, 1 bit: access request to the shared resource.
REQ-009 SHALL have port done, output, 4 bits: one-cycle completion pulse to the owner.
REQ-010 SHALL have port timeout_err, output, 1 bit: one-cycle abort pulse.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement exactly three states, IDLE, BUSY and RELEASE, with all outputs registered.
REQ-013 SHALL, in IDLE with req!=0, select a winner by round-robin, searching from (last+1) mod 4 upward with wrap, where last is the previous winner.
REQ-014 SHALL, on that arbitration edge, load sel=winner and gnt=1<<winner, set mem_valid=1, update last=winner, clear the wait counter, and enter BUSY.
- Latency: req sampled in cycle N gives gnt/sel/mem_valid high in cycle N+1.
REQ-015 SHALL, in BUSY, hold sel, gnt and mem_valid constant until exit from BUSY.
REQ-016 SHALL, in BUSY with mem_ready=1, assert done[owner] for exactly one cycle in the next cycle, clear gnt and mem_valid, and enter RELEASE.
REQ-017 SHALL, in BUSY with mem_ready=0, increment an 8-bit wait counter each cycle.
REQ-018 SHALL, when the wait counter reaches TIMEOUT-1 while mem_ready=0, pulse timeout_err for one cycle, leave done at 0, clear gnt and mem_valid, and enter RELEASE.
REQ-019 SHALL give mem_ready=1 priority over timeout when both occur in the same cycle: done is pulsed and timeout_err is not.
REQ-020 SHALL ignore changes on req while in BUSY; deassertion by the owner does not cancel the access.
REQ-021 SHALL stay in RELEASE for exactly one cycle, with gnt=0 and mem_valid=0, then enter IDLE.
- This yields a minimum of 3 cycles per transaction.
REQ-022 SHALL ignore mem_ready in IDLE and RELEASE.
REQ-023 SHALL keep sel at its last granted value in IDLE and RELEASE so the mux output stays stable.
REQ-024 SHALL keep gnt one-hot or zero, and done and timeout_err mutually exclusive, at all times.
REQ-025 SHALL bound waiting: a continuously asserted requester is granted within 4 transactions.

Reset
REQ-026 SHALL, on clk rising edge with rst=1, enter IDLE and set sel=0, gnt=0, mem_valid=0, done=0, timeout_err=0, busy=0, wait counter=0, last=3 (so requester 0 has first priority).
REQ-027 SHALL treat rst in BUSY or RELEASE as an abort: no done or timeout_err pulse is produced for the aborted access.
REQ-028 SHALL give rst priority over all other inputs in the same cycle.

Verification
REQ-029 SHALL pass single request: after reset, req=4'b0100 for 1 cycle, mem_ready=1 two cycles later -> sel=2, gnt=4'b0100, mem_valid=1 for 2 cycles, then done=4'b0100 for 1 cycle, then idle.
REQ-030 SHALL pass round-robin: req=4'b1111 held, mem_ready=1 always -> grant order 0,1,2,3,0 with sel 0,1,2,3,0, each new grant 3 cycles apart.
REQ-031 SHALL pass timeout: TIMEOUT=16, req=4'b0001, mem_ready held 0 -> mem_valid high 16 cycles, timeout_err 1 cycle, done stays 0, next grant possible 2 cycles later.
REQ-032 SHALL pass simultaneous ready and timeout: mem_ready=1 in the 16th BUSY cycle -> done=4'b0001, timeout_err=0.
REQ-033 SHALL pass reset mid-operation: rst=1 during BUSY with gnt=4'b1000 -> next cycle all outputs 0, no done; with req=4'b1001 afterwards -> requester 0 granted first.
REQ-034 SHALL pass withdrawal: the owner drops req in BUSY and mem_ready arrives later -> the transaction completes with done pulsed; the other pending requester (req=4'b0010) is granted next.
